// File: rtl/usb_tx_pkg.sv
// ----------------------------------------------------------------------------
// usb_tx_pkg
// Shared types and constants for the USB transmit path.
//   usb_ser_state_t   : state encoding of the DATA packet serializer
//   DATA_PAYLOAD_BITS : payload length fed through CRC16 and emitted
//   CRC16_W           : CRC16 width
//   SER_CNT_W         : bit counter width, covers 0..63 and 0..15
// ----------------------------------------------------------------------------
package usb_tx_pkg;

  localparam int DATA_PAYLOAD_BITS = 64;
  localparam int CRC16_W           = 16;
  localparam int SER_CNT_W         = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_FEED      = 3'd2,
    ST_WAIT_CRC  = 3'd3,
    ST_EMIT_DATA = 3'd4,
    ST_EMIT_CRC  = 3'd5
  } usb_ser_state_t;

endpackage

// File: rtl/piso_shift.sv
// ----------------------------------------------------------------------------
// piso_shift
// Parallel-in serial-out shift register with selectable shift direction.
//   clk, rst_n : clock, asynchronous active-low reset (clears the register)
//   load       : capture load_data (takes priority over shift_en)
//   load_data  : parallel word
//   shift_en   : advance one bit
//   msb_first  : 1 = present/shift from the MSB end, 0 = from the LSB end
//   ser_out    : bit currently presented (registered state, no input path)
// ----------------------------------------------------------------------------
module piso_shift #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             msb_first,
  output logic             ser_out
);

  logic [WIDTH-1:0] shreg_r;

  // Load or shift the stored word toward the presented end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
    end else if (load) begin
      shreg_r <= load_data;
    end else if (shift_en) begin
      if (msb_first) begin
        shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
      end else begin
        shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
      end
    end
  end

  assign ser_out = msb_first ? shreg_r[WIDTH-1] : shreg_r[0];

endmodule

// File: rtl/usb_data_pkt_serializer.sv
// ----------------------------------------------------------------------------
// usb_data_pkt_serializer
// Feeds a 64-bit DATA payload serially through the CRC16 block, collects the
// CRC, then emits payload (LSB first) followed by CRC (MSB first) as an
// 80-bit stream that honours a downstream stall.
//   clk, rst_n   : clock, asynchronous active-low reset
//   pkt_start    : request, sampled only in IDLE; pkt_data captured with it
//   busy         : state is not IDLE
//   crc16_start  : one-cycle start to the CRC block
//   crc_s_in     : serial payload bit to the CRC block
//   crc16_done   : CRC result valid; crc16_val carries it
//   crc16_rec    : one-cycle acknowledge to the CRC block
//   bit_out      : serial transmit bit, bit_valid qualifies it
//   bit_last     : marks the final CRC bit
//   stall        : downstream holds the current bit (EMIT states only)
//   pkt_done     : one-cycle pulse in the first IDLE cycle after the last bit
// ----------------------------------------------------------------------------
module usb_data_pkt_serializer
  import usb_tx_pkg::*;
#(
  parameter int PAYLOAD_BITS = DATA_PAYLOAD_BITS,
  parameter int CRC_W        = CRC16_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pkt_start,
  input  logic [PAYLOAD_BITS-1:0] pkt_data,
  output logic                    busy,
  output logic                    crc16_start,
  output logic                    crc_s_in,
  input  logic                    crc16_done,
  input  logic [CRC_W-1:0]        crc16_val,
  output logic                    crc16_rec,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    bit_last,
  input  logic                    stall,
  output logic                    pkt_done
);

  localparam logic [SER_CNT_W-1:0] CNT_ONE   = SER_CNT_W'(1);
  localparam logic [SER_CNT_W-1:0] DATA_LAST = SER_CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [SER_CNT_W-1:0] CRC_LAST  = SER_CNT_W'(CRC_W - 1);

  usb_ser_state_t        state_r;
  logic [SER_CNT_W-1:0]  cnt_r;
  logic                  crc16_rec_r;
  logic                  pkt_done_r;

  logic load_s;
  logic feed_shift_s;
  logic emit_shift_s;
  logic crc_load_s;
  logic crc_shift_s;
  logic feed_bit_s;
  logic emit_bit_s;
  logic crc_bit_s;

  // Shift-register strobes; stall only gates the two emit registers.
  always_comb begin
    load_s       = (state_r == ST_IDLE) && pkt_start;
    feed_shift_s = (state_r == ST_FEED);
    emit_shift_s = (state_r == ST_EMIT_DATA) && !stall;
    crc_load_s   = (state_r == ST_WAIT_CRC) && crc16_done;
    crc_shift_s  = (state_r == ST_EMIT_CRC) && !stall;
  end

  // Payload copy streamed into the CRC block.
  piso_shift #(.WIDTH(PAYLOAD_BITS)) u_feed_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_data (pkt_data),
    .shift_en  (feed_shift_s),
    .msb_first (1'b0),
    .ser_out   (feed_bit_s)
  );

  // Independent payload copy for the transmit stream, so stalls never
  // interfere with the CRC feed.
  piso_shift #(.WIDTH(PAYLOAD_BITS)) u_emit_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_data (pkt_data),
    .shift_en  (emit_shift_s),
    .msb_first (1'b0),
    .ser_out   (emit_bit_s)
  );

  // CRC holding register, transmitted MSB first.
  piso_shift #(.WIDTH(CRC_W)) u_crc_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (crc_load_s),
    .load_data (crc16_val),
    .shift_en  (crc_shift_s),
    .msb_first (1'b1),
    .ser_out   (crc_bit_s)
  );

  // Packet sequencing FSM with bit counter and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      crc16_rec_r <= 1'b0;
      pkt_done_r  <= 1'b0;
    end else begin
      crc16_rec_r <= 1'b0;
      pkt_done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pkt_start) begin
            state_r <= ST_START;
          end
        end
        ST_START: begin
          cnt_r   <= '0;
          state_r <= ST_FEED;
        end
        ST_FEED: begin
          if (cnt_r == DATA_LAST) begin
            cnt_r   <= '0;
            state_r <= ST_WAIT_CRC;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_CRC: begin
          if (crc16_done) begin
            crc16_rec_r <= 1'b1;
            cnt_r       <= '0;
            state_r     <= ST_EMIT_DATA;
          end
        end
        ST_EMIT_DATA: begin
          if (!stall) begin
            if (cnt_r == DATA_LAST) begin
              cnt_r   <= '0;
              state_r <= ST_EMIT_CRC;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        ST_EMIT_CRC: begin
          if (!stall) begin
            if (cnt_r == CRC_LAST) begin
              cnt_r      <= '0;
              pkt_done_r <= 1'b1;
              state_r    <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          cnt_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Remaining outputs decode state, counter and shift-register taps only,
  // so stall has no combinational path to the transmit outputs.
  assign busy        = (state_r != ST_IDLE);
  assign crc16_start = (state_r == ST_START);
  assign crc_s_in    = (state_r == ST_FEED) && feed_bit_s;
  assign crc16_rec   = crc16_rec_r;
  assign bit_valid   = (state_r == ST_EMIT_DATA) || (state_r == ST_EMIT_CRC);
  assign bit_out     = (state_r == ST_EMIT_DATA) ? emit_bit_s :
                       (state_r == ST_EMIT_CRC)  ? crc_bit_s  : 1'b0;
  assign bit_last    = (state_r == ST_EMIT_CRC) && (cnt_r == CRC_LAST);
  assign pkt_done    = pkt_done_r;

endmodule

// File: tb/tb_usb_data_pkt_serializer.sv
// ----------------------------------------------------------------------------
// tb_usb_data_pkt_serializer
// Directed sequence of packets with randomized payloads, CRC values, CRC
// latency and stall patterns. The bench plays the CRC16 block and the
// downstream bit stuffer, and predicts every output from the packet timeline
// and the expected 80-bit stream (payload LSB first, then CRC MSB first).
// ----------------------------------------------------------------------------
module tb_usb_data_pkt_serializer;

  logic        clk;
  logic        rst_n;
  logic        pkt_start;
  logic [63:0] pkt_data;
  logic        busy;
  logic        crc16_start;
  logic        crc_s_in;
  logic        crc16_done;
  logic [15:0] crc16_val;
  logic        crc16_rec;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_last;
  logic        stall;
  logic        pkt_done;

  int n_cmp = 0;
  int n_err = 0;

  usb_data_pkt_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pkt_start   (pkt_start),
    .pkt_data    (pkt_data),
    .busy        (busy),
    .crc16_start (crc16_start),
    .crc_s_in    (crc_s_in),
    .crc16_done  (crc16_done),
    .crc16_val   (crc16_val),
    .crc16_rec   (crc16_rec),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .bit_last    (bit_last),
    .stall       (stall),
    .pkt_done    (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        busy,        64'd0);
    check({tag, "_crc16_start"}, crc16_start, 64'd0);
    check({tag, "_crc_s_in"},    crc_s_in,    64'd0);
    check({tag, "_crc16_rec"},   crc16_rec,   64'd0);
    check({tag, "_bit_out"},     bit_out,     64'd0);
    check({tag, "_bit_valid"},   bit_valid,   64'd0);
    check({tag, "_bit_last"},    bit_last,    64'd0);
    check({tag, "_pkt_done"},    pkt_done,    64'd0);
  endtask

  // Called at the negedge of the cycle in which pkt_start is to be sampled.
  // d       : CRC latency; done rises d cycles after WAIT_CRC is entered
  //           (d=0: done raised early, already high on entry)
  // mode    : 0 no stall, 1 every third EMIT cycle plus 5-cycle burst at the
  //           data/CRC boundary, 2 random stall in every cycle
  // hold    : keep pkt_start high throughout
  // abort_at: assert reset when this consumed-bit index is presented (-1 off)
  // Returns at the negedge of the pkt_done cycle (or after a reset release).
  task automatic run_packet(input logic [63:0] data, input logic [15:0] crc,
                            input int d, input int mode, input bit hold,
                            input int abort_at);
    logic [79:0] stream;
    int   off;
    int   consumed;
    int   stalls;
    int   burst;
    int   emit_cyc;
    int   rec_pulses;
    int   done_on;
    int   emit_start;
    bit   fin;
    bit   prev_st;
    bit   exp_valid;
    bit   in_burst;
    logic pb_out;
    logic pb_last;

    for (int i = 0; i < 64; i++) stream[i] = data[i];
    for (int j = 0; j < 16; j++) stream[64 + j] = crc[15 - j];
    off = 0; consumed = 0; stalls = 0; burst = 0; emit_cyc = 0; rec_pulses = 0;
    fin = 1'b0; prev_st = 1'b0; pb_out = 1'b0; pb_last = 1'b0;
    done_on    = (d == 0) ? 60 : 66 + d;
    emit_start = 67 + d;

    check("idle_busy", busy, 64'd0);
    pkt_start  = 1'b1;
    pkt_data   = data;
    crc16_done = 1'b0;
    stall      = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;

    while (!fin) begin
      @(negedge clk);
      off++;
      pkt_start = hold;
      pkt_data  = {$urandom, $urandom};
      exp_valid = (off >= emit_start) && (consumed < 80);

      check("crc16_start", crc16_start, 64'(off == 1));
      if (off >= 2 && off <= 65) check("crc_s_in", crc_s_in, 64'(data[off - 2]));
      else check("crc_s_in_off", crc_s_in, 64'd0);
      if (crc16_rec === 1'b1) rec_pulses++;
      check("busy", busy, 64'(consumed < 80));
      check("bit_valid", bit_valid, 64'(exp_valid));
      check("bit_last", bit_last, 64'(exp_valid && consumed == 79));
      check("pkt_done", pkt_done, 64'(consumed == 80));
      if (exp_valid) check("bit_out", bit_out, 64'(stream[consumed]));
      if (prev_st) begin
        check("stall_hold_out", bit_out, 64'(pb_out));
        check("stall_hold_last", bit_last, 64'(pb_last));
      end

      if (consumed == 80) begin
        check("pkt_done_cycle", off, 64'(147 + d + stalls));
        check("crc16_rec_pulses", rec_pulses, 64'd1);
        fin = 1'b1;
      end else if (off > 1000) begin
        check("timeout_consumed", consumed, 64'd80);
        fin = 1'b1;
      end else if (exp_valid && consumed == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_reset");
        pkt_start = 1'b0; stall = 1'b0; crc16_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1'b1;
      end

      if (!fin) begin
        crc16_done = (off >= done_on) && (rec_pulses == 0);
        crc16_val  = crc16_done ? crc : 16'($urandom);
        if (exp_valid) begin
          in_burst = (consumed == 64) && (burst < 5);
          case (mode)
            1:       stall = in_burst || (emit_cyc % 3 == 2);
            2:       stall = ($urandom_range(0, 3) == 0);
            default: stall = 1'b0;
          endcase
          if (mode == 1 && in_burst) burst++;
          emit_cyc++;
          prev_st = stall;
          pb_out  = bit_out;
          pb_last = bit_last;
          if (stall) stalls++;
          else consumed++;
        end else begin
          stall   = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
          prev_st = 1'b0;
        end
      end else begin
        stall      = 1'b0;
        crc16_done = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pkt_start  = 1'b0;
    pkt_data   = 64'd0;
    crc16_done = 1'b0;
    crc16_val  = 16'd0;
    stall      = 1'b0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Reference packet, CRC done one cycle after FEED ends, no stall.
    run_packet(64'h0123_4567_89AB_CDEF, 16'hBEEF, 1, 0, 1'b0, -1);
    @(negedge clk);
    // Same packet with periodic stalls and a burst at the data/CRC boundary.
    run_packet(64'h0123_4567_89AB_CDEF, 16'hBEEF, 1, 1, 1'b0, -1);
    @(negedge clk);
    // Slow CRC block, random stall including FEED and WAIT_CRC.
    run_packet({$urandom, $urandom}, 16'($urandom), 10, 2, 1'b0, -1);
    @(negedge clk);
    // Reset while bit 20 is on the wire, then a clean packet with early done.
    run_packet({$urandom, $urandom}, 16'($urandom), 2, 0, 1'b0, 20);
    run_packet({$urandom, $urandom}, 16'($urandom), 0, 0, 1'b0, -1);
    @(negedge clk);
    // pkt_start held high across two back-to-back packets.
    run_packet(64'hFFFF_FFFF_FFFF_FFFF, 16'($urandom), 1, 0, 1'b1, -1);
    run_packet(64'h0000_0000_0000_0000, 16'($urandom), 1, 0, 1'b1, -1);
    pkt_start = 1'b0;
    // Random packets with random latency and stalls.
    repeat (3) begin
      @(negedge clk);
      run_packet({$urandom, $urandom}, 16'($urandom), int'($urandom_range(0, 5)), 2, 1'b0, -1);
    end
    @(negedge clk);
    check_all_zero("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
